stage_ex_md: RTL and testbench

//  Parametrised execute stage: ALU execution and branch resolution, plus an

---
 rtl/stage_ex_md.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_stage_ex_md.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_md.sv
// Execute stage: ALU, branch resolution, iterative multiply/divide unit owning HI/LO,
// and the EX2MEM pipeline register.
module stage_ex_md #(
  parameter int DATA_W     = 32,
  parameter int MD_STEP    = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [3:0]            in_alu_opt,
  input  logic                  in_alu_src_imm,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [DATA_W-1:0]     in_opr1,
  input  logic [DATA_W-1:0]     in_opr2,
  input  logic [3:0]            in_md_opt,
  input  logic [1:0]            in_branch_opt,
  input  logic [DATA_W-1:0]     in_branch_dest,
  input  logic [REG_ADDR_W-1:0] in_wb_reg_addr,
  input  logic [2:0]            in_mem_opt,
  output logic                  stall_out,
  output logic                  do_branch,
  output logic [DATA_W-1:0]     branch_dest,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [REG_ADDR_W-1:0] out_wb_reg_addr,
  output logic [2:0]            out_mem_opt
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] BR_EQZ    = 2'd1;
  localparam logic [1:0] BR_NEZ    = 2'd2;
  localparam logic [1:0] BR_UNCOND = 2'd3;

  localparam logic [2:0] MEM_OPT_NONE = 3'd0;

  localparam int N     = DATA_W / MD_STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

  md_state_t               r_state;
  md_state_t               w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [2*DATA_W-1:0]     r_prod;
  logic [DATA_W-1:0]       r_op2;
  logic [DATA_W-1:0]       r_op1_raw;
  logic                    r_is_div;
  logic                    r_sdiff;
  logic                    r_sign1;
  logic                    r_div0;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;

  logic [DATA_W-1:0]       w_alu_b;
  logic [DATA_W-1:0]       w_alu_res;
  logic [SH_W-1:0]         w_shamt;
  logic                    w_branch;
  logic                    w_stall;
  logic                    w_md_arith;
  logic                    w_md_start;
  logic                    w_signed;
  logic                    w_neg1;
  logic                    w_neg2;
  logic [DATA_W-1:0]       w_mag1;
  logic [DATA_W-1:0]       w_mag2;
  logic [DATA_W+MD_STEP-1:0] w_mul_sum;
  logic [2*DATA_W-1:0]     w_mul_next;
  logic [DATA_W:0]         w_div_rem;
  logic [DATA_W-1:0]       w_div_hi;
  logic [DATA_W-1:0]       w_div_lo;
  logic [2*DATA_W-1:0]     w_prod_fix;
  logic [DATA_W-1:0]       w_fin_hi;
  logic [DATA_W-1:0]       w_fin_lo;
  logic                    w_md_commit;
  logic                    w_mt_ok;
  logic                    w_no_wb;

  assign w_alu_b = in_alu_src_imm ? in_imm : in_opr2;
  assign w_shamt = w_alu_b[SH_W-1:0];

  // Shifts move opr1 by the low bits of opr2, so an immediate shift amount arrives via in_imm.
  always_comb begin
    w_alu_res = '0;
    case (in_alu_opt)
      ALU_ADD:  w_alu_res = in_opr1 + w_alu_b;
      ALU_SUB:  w_alu_res = in_opr1 - w_alu_b;
      ALU_AND:  w_alu_res = in_opr1 & w_alu_b;
      ALU_OR:   w_alu_res = in_opr1 | w_alu_b;
      ALU_XOR:  w_alu_res = in_opr1 ^ w_alu_b;
      ALU_NOR:  w_alu_res = ~(in_opr1 | w_alu_b);
      ALU_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(in_opr1) < $signed(w_alu_b))};
      ALU_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (in_opr1 < w_alu_b)};
      ALU_SLL:  w_alu_res = in_opr1 << w_shamt;
      ALU_SRL:  w_alu_res = in_opr1 >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(in_opr1) >>> w_shamt);
      ALU_LUI:  w_alu_res = {w_alu_b[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      default:  w_alu_res = '0;
    endcase
  end

  assign w_branch = in_valid & ~flush &
                    (((in_branch_opt == BR_EQZ) & (w_alu_res == '0)) |
                     ((in_branch_opt == BR_NEZ) & (w_alu_res != '0)) |
                     (in_branch_opt == BR_UNCOND));

  assign do_branch   = rst_n & w_branch;
  assign branch_dest = !rst_n ? '0 : (in_branch_dest[0] ? in_opr2 : in_branch_dest);

  assign w_md_arith = (in_md_opt == MD_MULT) | (in_md_opt == MD_MULTU) |
                      (in_md_opt == MD_DIV)  | (in_md_opt == MD_DIVU);
  assign w_md_start = (r_state == MD_IDLE) & in_valid & ~flush & w_md_arith;
  assign w_signed   = (in_md_opt == MD_MULT) | (in_md_opt == MD_DIV);
  assign w_neg1     = w_signed & in_opr1[DATA_W-1];
  assign w_neg2     = w_signed & in_opr2[DATA_W-1];
  assign w_mag1     = w_neg1 ? -in_opr1 : in_opr1;
  assign w_mag2     = w_neg2 ? -in_opr2 : in_opr2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        w_stall = w_md_start;
        if (w_md_start && !stall_in) w_next_state = MD_RUN;
      end
      MD_RUN: begin
        w_stall = ~flush;
        if (flush)                                   w_next_state = MD_IDLE;
        else if (!stall_in && r_cnt == CNT_W'(1))    w_next_state = MD_DONE;
      end
      MD_DONE: begin
        if (flush || !stall_in) w_next_state = MD_IDLE;
      end
      default: w_next_state = MD_IDLE;
    endcase
  end

  assign stall_out = rst_n & w_stall;

  // Shift-add multiply: low MD_STEP multiplier bits scale the multiplicand into the upper half.
  always_comb begin
    w_mul_sum = {{MD_STEP{1'b0}}, r_prod[2*DATA_W-1:DATA_W]};
    for (int k = 0; k < MD_STEP; k++) begin
      if (r_prod[k]) w_mul_sum = w_mul_sum + ({{MD_STEP{1'b0}}, r_op2} << k);
    end
  end

  generate
    if (MD_STEP < DATA_W) begin : g_mul_shift
      assign w_mul_next = {w_mul_sum, r_prod[DATA_W-1:MD_STEP]};
    end else begin : g_mul_full
      assign w_mul_next = w_mul_sum[2*DATA_W-1:0];
    end
  endgenerate

  // Restoring division: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  always_comb begin
    w_div_hi  = r_prod[2*DATA_W-1:DATA_W];
    w_div_lo  = r_prod[DATA_W-1:0];
    w_div_rem = '0;
    for (int k = 0; k < MD_STEP; k++) begin
      w_div_rem = {w_div_hi, w_div_lo[DATA_W-1]};
      w_div_lo  = {w_div_lo[DATA_W-2:0], 1'b0};
      if (w_div_rem >= {1'b0, r_op2}) begin
        w_div_rem   = w_div_rem - {1'b0, r_op2};
        w_div_lo[0] = 1'b1;
      end
      w_div_hi = w_div_rem[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_op2     <= '0;
      r_op1_raw <= '0;
      r_is_div  <= 1'b0;
      r_sdiff   <= 1'b0;
      r_sign1   <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_md_start && !stall_in) begin
            r_cnt     <= CNT_W'(N);
            r_prod    <= {{DATA_W{1'b0}}, w_mag1};
            r_op2     <= w_mag2;
            r_op1_raw <= in_opr1;
            r_is_div  <= (in_md_opt == MD_DIV) | (in_md_opt == MD_DIVU);
            r_sdiff   <= w_neg1 ^ w_neg2;
            r_sign1   <= w_neg1;
            r_div0    <= (in_opr2 == '0);
          end
        end
        MD_RUN: begin
          if (!flush && !stall_in) begin
            r_prod <= r_is_div ? {w_div_hi, w_div_lo} : w_mul_next;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up; the remainder follows the dividend, and a zero divisor bypasses fix-up entirely.
  assign w_prod_fix = r_sdiff ? -r_prod : r_prod;
  always_comb begin
    w_fin_hi = w_prod_fix[2*DATA_W-1:DATA_W];
    w_fin_lo = w_prod_fix[DATA_W-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fin_hi = r_op1_raw;
        w_fin_lo = '1;
      end else begin
        w_fin_hi = r_sign1 ? -r_prod[2*DATA_W-1:DATA_W] : r_prod[2*DATA_W-1:DATA_W];
        w_fin_lo = r_sdiff ? -r_prod[DATA_W-1:0] : r_prod[DATA_W-1:0];
      end
    end
  end

  assign w_md_commit = (r_state == MD_DONE) & ~flush & ~stall_in;
  assign w_mt_ok     = (r_state == MD_IDLE) & in_valid & ~flush & ~stall_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_md_commit) begin
      r_hi <= w_fin_hi;
      r_lo <= w_fin_lo;
    end else if (w_mt_ok) begin
      if (in_md_opt == MD_MTHI) r_hi <= in_opr1;
      if (in_md_opt == MD_MTLO) r_lo <= in_opr1;
    end
  end

  assign w_no_wb = w_md_arith | (in_md_opt == MD_MTHI) | (in_md_opt == MD_MTLO);

  // Bubbles clear only the control fields; data fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_mem_addr    <= '0;
      out_mem_data    <= '0;
      out_wb_reg_addr <= '0;
      out_mem_opt     <= MEM_OPT_NONE;
    end else if (stall_in) begin
      out_valid       <= out_valid;
    end else if (flush || !in_valid || w_stall) begin
      out_valid       <= 1'b0;
      out_wb_reg_addr <= '0;
      out_mem_opt     <= MEM_OPT_NONE;
    end else begin
      out_valid       <= 1'b1;
      out_result      <= (in_md_opt == MD_MFHI) ? r_hi :
                         (in_md_opt == MD_MFLO) ? r_lo : w_alu_res;
      out_mem_addr    <= w_alu_res;
      out_mem_data    <= in_opr2;
      out_wb_reg_addr <= w_no_wb ? '0 : in_wb_reg_addr;
      out_mem_opt     <= w_no_wb ? MEM_OPT_NONE : in_mem_opt;
    end
  end

endmodule

// File: tb/tb_stage_ex_md.sv
// Directed bench for stage_ex_md: ALU, branches, MD arithmetic corner cases,
// flush/stall interaction and async reset. A second MD_STEP=4 instance checks stall length.
module tb_stage_ex_md;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [1:0] BR_EQZ    = 2'd1;
  localparam logic [1:0] BR_NEZ    = 2'd2;
  localparam logic [1:0] BR_UNCOND = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallIn, flush, inValid, inAluSrcImm;
  logic [3:0]  inAluOpt, inMdOpt;
  logic [31:0] inImm, inOpr1, inOpr2, inBranchDest;
  logic [1:0]  inBranchOpt;
  logic [4:0]  inWbRegAddr;
  logic [2:0]  inMemOpt;

  logic        stallOut, doBranch, outValid;
  logic [31:0] branchDest, outResult, outMemAddr, outMemData;
  logic [4:0]  outWbRegAddr;
  logic [2:0]  outMemOpt;

  logic        stallOut4, doBranch4, outValid4;
  logic [31:0] branchDest4, outResult4, outMemAddr4, outMemData4;
  logic [4:0]  outWbRegAddr4;
  logic [2:0]  outMemOpt4;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  stage_ex_md #(.DATA_W(32), .MD_STEP(1), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stallIn), .flush(flush), .in_valid(inValid),
    .in_alu_opt(inAluOpt), .in_alu_src_imm(inAluSrcImm), .in_imm(inImm),
    .in_opr1(inOpr1), .in_opr2(inOpr2), .in_md_opt(inMdOpt), .in_branch_opt(inBranchOpt),
    .in_branch_dest(inBranchDest), .in_wb_reg_addr(inWbRegAddr), .in_mem_opt(inMemOpt),
    .stall_out(stallOut), .do_branch(doBranch), .branch_dest(branchDest),
    .out_valid(outValid), .out_result(outResult), .out_mem_addr(outMemAddr),
    .out_mem_data(outMemData), .out_wb_reg_addr(outWbRegAddr), .out_mem_opt(outMemOpt)
  );

  stage_ex_md #(.DATA_W(32), .MD_STEP(4), .REG_ADDR_W(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall_in(stallIn), .flush(flush), .in_valid(inValid),
    .in_alu_opt(inAluOpt), .in_alu_src_imm(inAluSrcImm), .in_imm(inImm),
    .in_opr1(inOpr1), .in_opr2(inOpr2), .in_md_opt(inMdOpt), .in_branch_opt(inBranchOpt),
    .in_branch_dest(inBranchDest), .in_wb_reg_addr(inWbRegAddr), .in_mem_opt(inMemOpt),
    .stall_out(stallOut4), .do_branch(doBranch4), .branch_dest(branchDest4),
    .out_valid(outValid4), .out_result(outResult4), .out_mem_addr(outMemAddr4),
    .out_mem_data(outMemData4), .out_wb_reg_addr(outWbRegAddr4), .out_mem_opt(outMemOpt4)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] aluOp, input logic [3:0] mdOp,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] wb);
    inValid      = 1'b1;
    inAluOpt     = aluOp;
    inMdOpt      = mdOp;
    inOpr1       = a;
    inOpr2       = b;
    inWbRegAddr  = wb;
    inAluSrcImm  = 1'b0;
    inImm        = '0;
    inBranchOpt  = '0;
    inBranchDest = '0;
    inMemOpt     = '0;
    flush        = 1'b0;
    stallIn      = 1'b0;
  endtask

  task automatic setIdle;
    applyStimulus(ALU_ADD, MD_NONE, 32'h0, 32'h0, 5'd0);
    inValid = 1'b0;
  endtask

  task automatic aluVec(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic useImm, input logic [31:0] imm,
                        input logic [31:0] exp);
    applyStimulus(op, MD_NONE, a, b, 5'd4);
    inAluSrcImm = useImm;
    inImm       = imm;
    inMemOpt    = 3'd2;
    step;
    checkOutput({tag, "_res"}, 64'(outResult), 64'(exp));
    checkOutput({tag, "_data"}, 64'(outMemData), 64'(b));
  endtask

  // Issues an MD op, holds it until stall_out drops, then retires it.
  task automatic runMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stallCnt, output int stall4Cnt);
    bit done4 = 0;
    applyStimulus(ALU_ADD, op, a, b, 5'd5);
    #1;
    stallCnt  = 0;
    stall4Cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (!done4) begin
        if (stallOut4) stall4Cnt++;
        else           done4 = 1;
      end
      if (!stallOut) break;
      stallCnt++;
      step;
    end
    checkOutput("md_reach_done", 64'(stallOut), 64'd0);
    step;
    checkOutput("md_retire_valid", 64'(outValid), 64'd1);
    checkOutput("md_retire_wb", 64'(outWbRegAddr), 64'd0);
    setIdle;
  endtask

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    applyStimulus(ALU_ADD, MD_MFHI, 32'h0, 32'h0, 5'd2);
    step;
    hi = outResult;
    applyStimulus(ALU_ADD, MD_MFLO, 32'h0, 32'h0, 5'd2);
    step;
    lo = outResult;
    setIdle;
  endtask

  task automatic mdCase(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int s1, s4;
    logic [31:0] hi, lo;
    runMd(op, a, b, s1, s4);
    checkOutput({tag, "_stall"}, 64'(s1), 64'd33);
    readHiLo(hi, lo);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int s1, s4;
    logic [31:0] hi, lo;

    setIdle;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_result", 64'(outResult), 64'd0);
    checkOutput("rst_memopt", 64'(outMemOpt), 64'd0);
    checkOutput("rst_stall", 64'(stallOut), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    aluVec("add",  ALU_ADD,  32'd5,        32'd7, 1'b0, 32'h0,  32'd12);
    checkOutput("add_valid", 64'(outValid), 64'd1);
    checkOutput("add_wb", 64'(outWbRegAddr), 64'd4);
    checkOutput("add_memopt", 64'(outMemOpt), 64'd2);
    checkOutput("add_addr", 64'(outMemAddr), 64'd12);
    aluVec("sub",  ALU_SUB,  32'd3,        32'd5, 1'b0, 32'h0,  32'hFFFFFFFE);
    aluVec("ori",  ALU_OR,   32'hF0,       32'd0, 1'b1, 32'h0F, 32'hFF);
    aluVec("slt",  ALU_SLT,  32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,  32'd1);
    aluVec("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,  32'd0);
    aluVec("sra",  ALU_SRA,  32'h80000000, 32'd0, 1'b1, 32'd4,  32'hF8000000);
    aluVec("sll",  ALU_SLL,  32'd1,        32'd0, 1'b1, 32'd31, 32'h80000000);
    aluVec("lui",  ALU_LUI,  32'd0,        32'd0, 1'b1, 32'h1234, 32'h12340000);

    applyStimulus(ALU_ADD, MD_NONE, 32'd1, 32'd1, 5'd6);
    stallIn = 1'b1;
    step;
    checkOutput("hold_result", 64'(outResult), 64'h12340000);
    checkOutput("hold_wb", 64'(outWbRegAddr), 64'd4);
    setIdle;
    step;
    checkOutput("bubble_valid", 64'(outValid), 64'd0);
    checkOutput("bubble_wb", 64'(outWbRegAddr), 64'd0);
    checkOutput("bubble_memopt", 64'(outMemOpt), 64'd0);

    applyStimulus(ALU_SUB, MD_NONE, 32'd9, 32'd9, 5'd0);
    inBranchOpt  = BR_EQZ;
    inBranchDest = 32'h40;
    #1;
    checkOutput("beq_taken", 64'(doBranch), 64'd1);
    checkOutput("beq_dest", 64'(branchDest), 64'h40);
    inBranchOpt = BR_NEZ;
    #1;
    checkOutput("bne_not_taken", 64'(doBranch), 64'd0);
    inBranchOpt  = BR_UNCOND;
    inBranchDest = 32'h41;
    inOpr2       = 32'h1000;
    #1;
    checkOutput("jr_taken", 64'(doBranch), 64'd1);
    checkOutput("jr_dest", 64'(branchDest), 64'h1000);
    flush = 1'b1;
    #1;
    checkOutput("flush_no_branch", 64'(doBranch), 64'd0);
    setIdle;
    step;

    runMd(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, s1, s4);
    checkOutput("multu_stall_cycles", 64'(s1), 64'd33);
    checkOutput("step4_stall_cycles", 64'(s4), 64'd9);
    readHiLo(hi, lo);
    checkOutput("multu_hi", 64'(hi), 64'hFFFFFFFE);
    checkOutput("multu_lo", 64'(lo), 64'h00000001);

    mdCase("div_m7_2",    MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    mdCase("div_min_m1",  MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    mdCase("divu_5_0",    MD_DIVU, 32'd5,        32'd0,        32'h5,        32'hFFFFFFFF);
    mdCase("mult_m3_4",   MD_MULT, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4);
    mdCase("divu_100_7",  MD_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    mdCase("div_7_m2",    MD_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    mdCase("div_m8_0",    MD_DIV,  32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
    mdCase("mult_max_2",  MD_MULT, 32'h7FFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFE);

    applyStimulus(ALU_ADD, MD_MTHI, 32'h1234, 32'h0, 5'd7);
    step;
    checkOutput("mthi_wb", 64'(outWbRegAddr), 64'd0);
    applyStimulus(ALU_ADD, MD_MTLO, 32'h1234, 32'h0, 5'd7);
    step;
    applyStimulus(ALU_ADD, MD_MULT, 32'd3, 32'd5, 5'd5);
    step;
    repeat (9) step;
    checkOutput("run10_stall", 64'(stallOut), 64'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall_drop", 64'(stallOut), 64'd0);
    step;
    checkOutput("flush_bubble", 64'(outValid), 64'd0);
    setIdle;
    #1;
    checkOutput("flush_idle", 64'(stallOut), 64'd0);
    repeat (40) step;
    readHiLo(hi, lo);
    checkOutput("flush_hi_kept", 64'(hi), 64'h1234);
    checkOutput("flush_lo_kept", 64'(lo), 64'h1234);

    applyStimulus(ALU_ADD, MD_MULT, 32'd6, 32'd7, 5'd5);
    #1;
    for (int c = 0; c < 200 && stallOut; c++) step;
    checkOutput("done_reached", 64'(stallOut), 64'd0);
    stallIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      checkOutput("done_hold_valid", 64'(outValid), 64'd0);
      checkOutput("done_hold_stall", 64'(stallOut), 64'd0);
    end
    stallIn = 1'b0;
    step;
    checkOutput("done_release_valid", 64'(outValid), 64'd1);
    setIdle;
    readHiLo(hi, lo);
    checkOutput("mult_6_7_hi", 64'(hi), 64'd0);
    checkOutput("mult_6_7_lo", 64'(lo), 64'd42);

    applyStimulus(ALU_ADD, MD_MTHI, 32'hABCD, 32'h0, 5'd0);
    step;
    applyStimulus(ALU_ADD, MD_DIV, 32'd100, 32'd3, 5'd5);
    inBranchOpt  = BR_UNCOND;
    inBranchDest = 32'h80;
    repeat (5) step;
    checkOutput("middiv_stall", 64'(stallOut), 64'd1);
    checkOutput("middiv_result", 64'(outResult), 64'hABCD);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_stall", 64'(stallOut), 64'd0);
    checkOutput("rst_mid_branch", 64'(doBranch), 64'd0);
    checkOutput("rst_mid_dest", 64'(branchDest), 64'd0);
    checkOutput("rst_mid_result", 64'(outResult), 64'd0);
    checkOutput("rst_mid_addr", 64'(outMemAddr), 64'd0);
    checkOutput("rst_mid_valid", 64'(outValid), 64'd0);
    setIdle;
    step;
    rst_n = 1'b1;
    step;
    readHiLo(hi, lo);
    checkOutput("rst_hi_cleared", 64'(hi), 64'd0);
    checkOutput("rst_lo_cleared", 64'(lo), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
